// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES inverse cipher.
// Holds the FSM state enum, the block type and the inverse round primitives.
package aes_pkg;

    localparam int block_w = 128;

    typedef logic [block_w-1:0] block_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } state_t;

    // Inverse S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] inv_sbox_tbl = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return inv_sbox_tbl[(255 - int'(b))*8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates right by r.
    function automatic block_t inv_shift_rows(input block_t s);
        block_t r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c - row + 4) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic block_t inv_sub_bytes(input block_t s);
        block_t r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        end
        return r;
    endfunction

    function automatic block_t inv_mix_columns(input block_t s);
        block_t r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c      -: 8];
            a1 = s[127 - 32*c - 8  -: 8];
            a2 = s[127 - 32*c - 16 -: 8];
            a3 = s[127 - 32*c - 24 -: 8];
            r[127 - 32*c      -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            r[127 - 32*c - 8  -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            r[127 - 32*c - 16 -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            r[127 - 32*c - 24 -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: invShiftRows, invSubBytes, AddRoundKey, invMixColumns.
// The final round skips invMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [block_w-1:0] in_state,
    input  logic [block_w-1:0] round_key,
    input  logic               is_final,
    output logic [block_w-1:0] out_state
);

    block_t keyed;

    assign keyed     = inv_sub_bytes(inv_shift_rows(in_state)) ^ round_key;
    assign out_state = is_final ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse-cipher controller: one inverse round per clock over NR rounds,
// round keys fetched from an external store through key_idx/round_key.
module aes_inv_cipher_ctrl
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [block_w-1:0] ciphertext,
    output logic [3:0]         key_idx,
    input  logic [block_w-1:0] round_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [block_w-1:0] plaintext,
    output logic               busy
);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] rnd;
    block_t     state_reg;
    block_t     round_out;
    logic       is_final;

    assign is_final = (state == FINAL);

    aes_inv_round u_round (
        .in_state (state_reg),
        .round_key(round_key),
        .is_final (is_final),
        .out_state(round_out)
    );

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        key_idx   = 4'(NR);
        case (state)
            IDLE: begin
                if (in_valid) state_nxt = (NR == 1) ? FINAL : ROUND;
            end
            ROUND: begin
                key_idx = rnd;
                if (rnd == 4'd1) state_nxt = FINAL;
            end
            FINAL: begin
                key_idx   = 4'd0;
                state_nxt = DONE;
            end
            DONE: begin
                key_idx = 4'd0;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The counter parks at 1 on the last ROUND edge rather than wrapping through 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rnd       <= 4'd0;
            state_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= ciphertext ^ round_key;
                        rnd       <= 4'(NR - 1);
                    end
                end
                ROUND: begin
                    state_reg <= round_out;
                    if (rnd != 4'd1) rnd <= rnd - 4'd1;
                end
                FINAL: state_reg <= round_out;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign plaintext = state_reg;

endmodule

// File: doc/aes_inv_cipher_ctrl.md
# aes_inv_cipher_ctrl

Iterative AES inverse-cipher controller: accepts one 128-bit ciphertext block, sequences the combinational inverse-round datapath (invShiftRows, invSubBytes, AddRoundKey, invMixColumns) once per clock over NR rounds, and returns the plaintext block. It sits between the decryption input stream and the output stream. It fetches one round key per cycle from an external key-schedule store through a combinational index/data port.

## Interface
- NR, 10, number of rounds; legal values are 10, 12 and 14 (AES-128/192/256).
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  ciphertext on `ciphertext` is valid.
- in_ready  output  1  controller can accept a block; high only in IDLE.
- ciphertext  input  128  input block; byte 0 is bits [127:120], column-major state layout.
- key_idx  output  4  round-key index requested this cycle.
- round_key  input  128  key store data for `key_idx`; combinational, valid in the same cycle.
- out_valid  output  1  `plaintext` is valid; high only in DONE.
- out_ready  input  1  downstream accepts `plaintext`.
- plaintext  output  128  result block; driven directly from the state register.
- busy  output  1  high in ROUND, FINAL and DONE.

## Operation
- States and transitions:
  - IDLE: key_idx = NR. If in_valid is high, then at the edge state_reg <= ciphertext ^ round_key, rnd <= NR-1, and the FSM moves to ROUND (or to FINAL if NR-1 == 0, which is never legal).
  - ROUND: key_idx = rnd. At the edge state_reg <= invMixColumns(invSubBytes(invShiftRows(state_reg)) ^ round_key) and rnd <= rnd-1. If rnd == 1, the FSM moves to FINAL.
  - FINAL: key_idx = 0. At the edge state_reg <= invSubBytes(invShiftRows(state_reg)) ^ round_key, and the FSM moves to DONE.
  - DONE: out_valid = 1. If out_ready is high, the FSM moves to IDLE at the edge. state_reg and plaintext hold until that handshake.
- While out_valid is high, plaintext must not change.
- in_valid is ignored outside IDLE. ciphertext is sampled only on the accept edge, so upstream may change it afterwards.
- rnd is a 4-bit down-counter. It never wraps: it is loaded only in IDLE and never decremented below 1 in ROUND.
- In IDLE, FINAL and DONE, key_idx is a fixed function of state (NR, 0, and 0 respectively). This keeps the key-store address stable.
- Reset, including reset asserted mid-operation: FSM goes to IDLE, rnd = 0, state_reg = 0. The block in progress is discarded with no partial output. On the cycle after rst deasserts, in_ready = 1, out_valid = 0 and busy = 0.

## Timing
- Reset values: in_ready = 1 (IDLE), out_valid = 0, busy = 0, plaintext = 0, key_idx = NR.
- Accept edge E0 is the edge where in_valid and in_ready are both high.
- Rounds NR-1 down to 1 execute on edges E1 through E(NR-1). The final round executes on E(NR).
- out_valid rises after E(NR): 10 cycles for NR = 10.
- If out_ready is held high, the output handshake completes at E(NR+1). IDLE then accepts the next block at E(NR+2), giving a throughput of one block per NR+2 cycles.
- There are no combinational paths from inputs to in_ready, out_valid or plaintext. key_idx depends on registered state only.

## Structure
- Package aes_pkg holds:
  - the state_t enum (IDLE, ROUND, FINAL, DONE);
  - the block width constant 128;
  - the inverse S-box table function;
  - the GF(2^8) xtime/multiply functions used by invMixColumns.
- Sub-module aes_inv_round: purely combinational, with ports (in_state, round_key, is_final, out_state). It instantiates the existing invShiftRows, invSubBytes and invMixColumns blocks; invMixColumns is bypassed when is_final = 1.
- The controller itself contains the FSM, the rnd counter, state_reg, and the IDLE-state AddRoundKey XOR.

## Test plan
- FIPS-197 C.1 vector. Key store holds the expansion of key 000102030405060708090a0b0c0d0e0f (key 10 = 13111d7fe3944a17f307a78b4d2b30c5). Drive ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a. Required: plaintext 00112233445566778899aabbccddeeff, with out_valid rising exactly 10 cycles after accept.
- FIPS-197 Appendix B vector. Key 2b7e151628aed2a6abf7158809cf4f3c (key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6), ciphertext 3925841d02dc09fbdc118597196a0b32. Required: plaintext 3243f6a8885a308d313198a2e0370734.
- Key-index sequence: monitor key_idx from the accept cycle onward. Required sequence: 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0; it then holds 0 while in DONE.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE. Required: out_valid, plaintext and busy stay stable, and in_ready stays 0 with in_valid held high. After out_ready = 1 for one cycle, IDLE is reached on the next edge.
- Back-to-back: hold in_valid high with the C.1 block followed by the Appendix B block, and out_ready held high. Required: both plaintexts are correct, in order, and the second accept occurs 12 cycles after the first.
- Reset mid-operation: assert rst for one cycle while key_idx = 5. Required on the next cycle: out_valid = 0, busy = 0, in_ready = 1, plaintext = 0. A subsequent C.1 block must then decrypt correctly.
